imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/soc_pkg.sv | 21 ++
 rtl/imem_array.sv | 28 ++
 rtl/imem_responder.sv | 129 ++++++++++++
 tb/tb_imem_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared types and constants for the instruction-memory responder slice:
// FSM encoding, default bus widths, counter width and the error-data value.
package soc_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ERR_DATA       = 0;
  localparam int unsigned CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word-index width for a memory of the given depth (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port for program load and one
// asynchronous read port used by the responder at capture time.
module imem_array
  import soc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned IDX_WIDTH = idx_width(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // NOTE: the array has no reset on purpose; a loaded program must survive
  // reset, and resetting a RAM would also prevent mapping it onto block memory.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed latency, flush,
// misaligned/out-of-range error reporting and a backdoor program-load port.
module imem_responder
  import soc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int unsigned          IDX_WIDTH = idx_width(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("imem_responder: LATENCY must be within 1..15");
  end

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [ADDR_WIDTH-1:0]   rsp_addr_q;
  logic                    rsp_err_q;

  logic                    accept, capture, cap_err, ld_ok;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign accept = req_valid & req_ready;

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational process assigns a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (flush) state_d = IDLE;
            else if (cnt_q == CNT_WIDTH'(1)) state_d = RESP;
      RESP: if (flush || rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !flush;
    rsp_valid = (state_q == RESP);
  end

  // The LATENCY=1 path captures straight from the request bus.
  assign capture  = (state_d == RESP) && (state_q != RESP);
  assign cap_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign cap_err  = (cap_addr[1:0] != 2'b00) ||
                    ((cap_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH));

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (accept) begin
      cnt_d  = CNT_LOAD;
      addr_d = req_addr;
    end else if (state_q != IDLE && flush) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      if (capture) begin
        rsp_err_q  <= cap_err;
        rsp_addr_q <= cap_addr;
        rsp_data_q <= cap_err ? DATA_WIDTH'(ERR_DATA) : rd_data;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_err  = rsp_err_q;

  // Misaligned or out-of-range loads are dropped rather than aliased.
  assign ld_ok = ld_en && (ld_addr[1:0] == 2'b00) &&
                 ((ld_addr >> 2) < ADDR_WIDTH'(MEM_DEPTH));

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (ld_ok),
    .waddr_i (ld_addr[IDX_WIDTH+1:2]),
    .wdata_i (ld_data),
    .raddr_i (cap_addr[IDX_WIDTH+1:2]),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the back-to-back throughput case.
module tb_imem_responder;

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, ld_en;
  logic [31:0] ld_addr, ld_data;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, rsp_data, rsp_addr;

  logic        req_valid_l1, req_ready_l1, rsp_valid_l1, rsp_ready_l1, rsp_err_l1;
  logic [31:0] req_addr_l1, rsp_data_l1, rsp_addr_l1;

  int total = 0;
  int bad   = 0;

  imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_l1), .req_ready(req_ready_l1),
    .req_addr(req_addr_l1), .flush(flush), .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready_l1),
    .rsp_data(rsp_data_l1), .rsp_addr(rsp_addr_l1), .rsp_err(rsp_err_l1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Issue one request on the LATENCY=2 instance with rsp_ready=1 and check
  // acceptance, latency, response fields and the return to idle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                       input string nm);
    int lat;
    req_valid = 1'b1; req_addr = a; #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_accept: req_ready=%b expected 1", nm, req_ready);
    end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick(); lat++;
    end
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL %s_latency: got %0d expected 2", nm, lat);
    end
    total++;
    if (rsp_data !== ed) begin
      bad++; $display("FAIL %s_data: got %h expected %h", nm, rsp_data, ed);
    end
    total++;
    if (rsp_err !== ee) begin
      bad++; $display("FAIL %s_err: got %b expected %b", nm, rsp_err, ee);
    end
    total++;
    if (rsp_addr !== a) begin
      bad++; $display("FAIL %s_addr: got %h expected %h", nm, rsp_addr, a);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_idle: rsp_valid=%b req_ready=%b expected 0/1",
                      nm, rsp_valid, req_ready);
    end
  endtask

  // Count rsp_valid cycles on the LATENCY=2 instance over n cycles.
  task automatic expect_silence(input int n, input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (rsp_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL %s: rsp_valid seen %0d cycles expected 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags: valid=%b err=%b expected 0/0", rsp_valid, rsp_err);
    end
    total++;
    if (rsp_data !== 32'h0 || rsp_addr !== 32'h0) begin
      bad++; $display("FAIL reset_regs: data=%h addr=%h expected 0/0", rsp_data, rsp_addr);
    end
    reset_n = 1'b1; #1;
    total++;
    if (req_ready !== 1'b1 || req_ready_l1 !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b/%b expected 1/1", req_ready, req_ready_l1);
    end
    tick();
  endtask

  task automatic test_basic();
    fetch(32'h0, W0, 1'b0, "basic0");
    fetch(32'h4, W1, 1'b0, "basic1");
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== W1 || rsp_addr !== 32'h4 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h addr=%h ready=%b expected 1/%h/00000004/0",
                 i, rsp_valid, rsp_data, rsp_addr, req_ready, W1);
      end
      // Overwrite the held word mid-stall; the registered response must not move.
      ld_en = (i == 1); ld_addr = 32'h4; ld_data = 32'hFFFF_FFFF;
      tick();
      ld_en = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    load(32'h4, W1);
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0; flush = 1'b1; #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL flush_wait_ready: got %b expected 0", req_ready);
    end
    tick();
    flush = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_wait_drop: rsp_valid=%b expected 0", rsp_valid);
    end
    fetch(32'h4, W1, 1'b0, "flush_refetch");

    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL flush_resp_pre: rsp_valid=%b expected 1", rsp_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_silence(4, "flush_resp_drop");

    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0; #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL flush_idle_ready: got %b expected 0", req_ready);
    end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    expect_silence(4, "flush_idle_noaccept");
  endtask

  task automatic test_errors();
    fetch(32'h2, 32'h0, 1'b1, "err_misaligned");
    fetch(32'h1000, 32'h0, 1'b1, "err_range");
    load(32'hFFC, 32'h1234_5678);
    fetch(32'hFFC, 32'h1234_5678, 1'b0, "last_word");
    load(32'h2, 32'hDEAD_BEEF);
    load(32'h1000, 32'hCAFE_F00D);
    fetch(32'h0, W0, 1'b0, "ignored_loads");
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0; reset_n = 1'b0; #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_wait_valid: got %b expected 0", rsp_valid);
    end
    tick();
    reset_n = 1'b1; #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_wait_ready: got %b expected 1", req_ready);
    end
    expect_silence(4, "rst_wait_silent");
    fetch(32'h0, W0, 1'b0, "after_reset");
  endtask

  task automatic test_latency1();
    logic [31:0] exp_d;
    rsp_ready_l1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid_l1 = 1'b1;
      if (k % 2 == 0) req_addr_l1 = ((k / 2) % 2 == 1) ? 32'h4 : 32'h0;
      #1;
      total++;
      if (req_ready_l1 !== (k % 2 == 0) || rsp_valid_l1 !== (k % 2 == 1)) begin
        bad++;
        $display("FAIL l1_cycle%0d: ready=%b valid=%b expected %b/%b",
                 k, req_ready_l1, rsp_valid_l1, (k % 2 == 0), (k % 2 == 1));
      end
      if (k % 2 == 1) begin
        exp_d = (((k - 1) / 2) % 2 == 1) ? W1 : W0;
        total++;
        if (rsp_data_l1 !== exp_d || rsp_err_l1 !== 1'b0) begin
          bad++;
          $display("FAIL l1_data%0d: data=%h err=%b expected %h/0",
                   k, rsp_data_l1, rsp_err_l1, exp_d);
        end
      end
      tick();
    end
    req_valid_l1 = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    req_valid_l1 = 1'b0; req_addr_l1 = '0; rsp_ready_l1 = 1'b1;

    test_reset();
    load(32'h0, W0);
    load(32'h4, W1);
    test_basic();
    test_backpressure();
    test_flush();
    test_errors();
    test_reset_mid_wait();
    test_latency1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
